// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer (IDLE/ACCESS/RESP) in front of a single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise the core port has fixed priority.
module dmem_arbiter #(
    parameter int AW    = 32,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic [1:0]    c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [31:0]   c_rdata,
    output logic          c_err,
    input  logic          d_req,
    input  logic [1:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wd,
    output logic [1:0]    m_we,
    input  logic [31:0]   m_rd
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t        state;
    logic          owner;
    logic          oor_r;
    logic [1:0]    m_we_r;
    logic          win;
    logic          arb;
    logic [1:0]    win_we;
    logic [AW-1:0] win_addr;
    logic [31:0]   win_wdata;
    logic          win_oor;
`ifdef DMEM_ARB_RR_EN
    logic          rr_last;
    assign win = (c_req & d_req) ? ~rr_last : d_req;
`else
    assign win = ~c_req;
`endif
    assign arb       = (state != ACCESS) & (c_req | d_req);
    assign win_we    = win ? d_we : c_we;
    assign win_addr  = win ? d_addr : c_addr;
    assign win_wdata = win ? d_wdata : c_wdata;
    assign win_oor   = win_addr >= AW'(DEPTH);
    // the write strobe must never reach the memory while reset is asserted
    assign m_we = rst ? 2'b00 : m_we_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            oor_r    <= 1'b0;
            m_we_r   <= 2'b00;
            m_addr   <= '0;
            m_wd     <= '0;
            c_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            c_rdata  <= '0;
            d_rdata  <= '0;
            c_err    <= 1'b0;
            d_err    <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr_last  <= 1'b0;
`endif
        end else begin
            c_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            m_we_r   <= 2'b00;
            if (state == ACCESS) begin
                state <= RESP;
                if (owner) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= oor_r ? 32'h0 : m_rd;
                    d_err    <= oor_r;
                end else begin
                    c_rvalid <= 1'b1;
                    c_rdata  <= oor_r ? 32'h0 : m_rd;
                    c_err    <= oor_r;
                end
            end else if (arb) begin
                state  <= ACCESS;
                owner  <= win;
                oor_r  <= win_oor;
                m_addr <= win_addr;
                m_wd   <= win_wdata;
                m_we_r <= win_oor ? 2'b00 : win_we;
                c_gnt  <= ~win;
                d_gnt  <= win;
`ifdef DMEM_ARB_RR_EN
                rr_last <= win;
`endif
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a bench-side 256-word memory.
// Tie-break expectations follow DMEM_ARB_RR_EN.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, d_req;
    logic [1:0]  c_we, d_we, m_we;
    logic [31:0] c_addr, d_addr, c_wdata, d_wdata;
    logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0] c_rdata, d_rdata, m_addr, m_wd, m_rd;
    logic [31:0] mem [256];
    logic        mem_clr;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rd;
    logic        er;
    logic [1:0]  ws;
    logic [3:0]  who;
    logic [3:0]  who_exp;
    int          at [4];
    int          g;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_addr(m_addr), .m_wd(m_wd), .m_we(m_we), .m_rd(m_rd)
    );

    always #5 clk = ~clk;

    assign m_rd = mem[m_addr[7:0]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (m_we != 2'b00 && m_addr < 32'd256) begin
            mem[m_addr[7:0]] <= m_we == 2'b01 ? {24'h0, m_wd[7:0]} :
                                m_we == 2'b10 ? {16'h0, m_wd[15:0]} : m_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_access(input logic port, input logic [1:0] we, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata,
                             output logic err, output logic [1:0] we_seen);
        int n;
        n = 0;
        @(negedge clk);
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? d_gnt : c_gnt) && n < 20);
        check("gnt_latency", n, 1);
        check("other_gnt", port ? c_gnt : d_gnt, 0);
        check("m_addr", m_addr, addr);
        we_seen = m_we;
        c_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check("rvalid", port ? d_rvalid : c_rvalid, 1);
        check("other_rvalid", port ? c_rvalid : d_rvalid, 0);
        rdata = port ? d_rdata : c_rdata;
        err = port ? d_err : c_err;
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_m_we", m_we, 0);
        check("rst_pulses", {c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err}, 0);
        check("rst_c_rdata", c_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wd", m_wd, 0);
        rst = 1'b0; mem_clr = 1'b0;

        // simultaneous requests held for four accesses
        c_req = 1; d_req = 1; c_addr = 5; d_addr = 6;
        who = '0; g = 0;
        for (int cyc = 1; cyc <= 12 && g < 4; cyc++) begin
            @(negedge clk);
            if (c_gnt | d_gnt) begin
                check("tie_single_gnt", {31'h0, c_gnt & d_gnt}, 0);
                who[g] = d_gnt;
                at[g] = cyc;
                g++;
                if (g == 4) begin
                    c_req = 0; d_req = 0;
                end
            end
        end
        c_req = 0; d_req = 0;
`ifdef DMEM_ARB_RR_EN
        who_exp = 4'b0101;
`else
        who_exp = 4'b0000;
`endif
        check("tie_count", g, 4);
        check("tie_order", {28'h0, who}, {28'h0, who_exp});
        check("tie_first_at", at[0], 1);
        check("tie_last_at", at[3], 7);
        @(negedge clk);

        do_access(0, 2'b11, 5, 32'hDEADBEEF, rd, er, ws);
        check("sw_m_we", ws, 2'b11);
        do_access(0, 2'b00, 5, 0, rd, er, ws);
        check("lw_m_we", ws, 2'b00);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err", er, 0);

        do_access(0, 2'b01, 3, 32'h12345678, rd, er, ws);
        check("sb_m_we", ws, 2'b01);
        do_access(0, 2'b00, 3, 0, rd, er, ws);
        check("lb_rdata", rd, 32'h00000078);

        do_access(1, 2'b00, 5, 0, rd, er, ws);
        check("dma_lw_rdata", rd, 32'hDEADBEEF);
        check("dma_lw_err", er, 0);
        do_access(1, 2'b11, 300, 32'h55AA55AA, rd, er, ws);
        check("oor_m_we", ws, 2'b00);
        check("oor_err", er, 1);
        check("oor_rdata", rd, 0);
        check("oor_mem44", mem[44], 0);
        check("c_rdata_hold", c_rdata, 32'h00000078);

        // reset lands while the core store is in ACCESS
        @(negedge clk);
        c_req = 1; c_we = 2'b11; c_addr = 7; c_wdata = 32'hAAAA5555;
        @(negedge clk);
        check("rstacc_gnt", c_gnt, 1);
        rst = 1'b1;
        #1;
        check("rstacc_m_we", m_we, 0);
        c_req = 0;
        @(negedge clk);
        rst = 1'b0;
        check("rstacc_rvalid", c_rvalid, 0);
        @(negedge clk);
        check("rstacc_rvalid2", c_rvalid, 0);
        check("rstacc_mem7", mem[7], 0);
        do_access(0, 2'b00, 7, 0, rd, er, ws);
        check("rstacc_lw7", rd, 0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_m_we", m_we, 0);
            check("idle_pulses", {c_gnt, d_gnt, c_rvalid, d_rvalid}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
